// File: rtl/snoop_dispatcher.sv
// Snoop dispatcher: turns one coherent request plus its sharer vector into a
// serial stream of snoops, collects the responses and reports a completion.
module snoop_dispatcher #(
    parameter int unsigned WIDTH   = 33,
    parameter int unsigned NUM_RN  = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [WIDTH-1:0]  req_tag,
    input  logic [6:0]        req_opcode,
    input  logic [6:0]        req_nid,
    input  logic [NUM_RN-1:0] req_sharers,
    output logic              snp_valid,
    input  logic              snp_ready,
    output logic [WIDTH-1:0]  snp_tag,
    output logic [6:0]        snp_opcode,
    output logic [NUM_RN-1:0] snp_tgt,
    input  logic              rsp_valid,
    input  logic [NUM_RN-1:0] rsp_src,
    input  logic              rsp_dirty,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [WIDTH-1:0]  done_tag,
    output logic [2:0]        done_cnt,
    output logic              done_dirty,
    output logic              done_tmo,
    output logic              err_spur
);

    localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  tag_q, tag_d;
    logic [6:0]        opc_q, opc_d;
    logic [NUM_RN-1:0] issue_q, issue_d;
    logic [NUM_RN-1:0] pend_q, pend_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              dirty_q, dirty_d;
    logic              tmo_q, tmo_d;
    logic              spur_q, spur_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;

    logic [NUM_RN-1:0] targets;
    logic [NUM_RN-1:0] lowest;
    logic [NUM_RN-1:0] pend_next;
    logic [6:0]        map_opc;
    logic              map_ok;
    logic [2:0]        tgt_cnt;
    logic              rsp_hit;
    logic              snp_hs;
    logic              unused_nid;

    assign unused_nid = ^req_nid;

    assign targets = req_sharers & ~req_nid[NUM_RN-1:0];
    assign lowest  = issue_q & (~issue_q + NUM_RN'(1));

    always_comb begin
        map_ok  = 1'b1;
        map_opc = 7'b0000000;
        unique case (req_opcode)
            7'b0000111: map_opc = 7'b0000001;
            7'b0000001: map_opc = 7'b0000111;
            7'b0011011: map_opc = 7'b0001001;
            default:    map_ok  = 1'b0;
        endcase
    end

    // Saturating popcount so wider NUM_RN still fits the 3-bit count field.
    always_comb begin
        int unsigned c;
        c = 0;
        for (int unsigned i = 0; i < NUM_RN; i++) begin
            c += int'(targets[i]);
        end
        tgt_cnt = (c > 7) ? 3'd7 : 3'(c);
    end

    assign req_ready  = (state_q == StIdle);
    assign snp_valid  = (state_q == StIssue);
    assign snp_tgt    = (state_q == StIssue) ? lowest : '0;
    assign snp_tag    = tag_q;
    assign snp_opcode = opc_q;
    assign done_valid = (state_q == StDone);
    assign done_tag   = tag_q;
    assign done_cnt   = cnt_q;
    assign done_dirty = dirty_q;
    assign done_tmo   = tmo_q;
    assign err_spur   = spur_q;

    assign snp_hs = snp_valid && snp_ready;

    // A bit only becomes pending after its handshake, so a response in the same
    // cycle as its own handshake is rejected as spurious.
    assign rsp_hit = rsp_valid && ((state_q == StIssue) || (state_q == StWait)) &&
                     (rsp_src != '0) && ((rsp_src & ~pend_q) == '0);

    always_comb begin
        pend_next = pend_q | (snp_hs ? snp_tgt : '0);
        if (rsp_hit) begin
            pend_next = pend_next & ~rsp_src;
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        opc_d   = opc_q;
        issue_d = issue_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        dirty_d = dirty_q;
        tmo_d   = tmo_q;
        tmr_d   = '0;
        spur_d  = rsp_valid && !rsp_hit;

        if (rsp_hit) begin
            dirty_d = dirty_q | rsp_dirty;
        end

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    tag_d   = req_tag;
                    opc_d   = map_opc;
                    pend_d  = '0;
                    dirty_d = 1'b0;
                    tmo_d   = 1'b0;
                    if (map_ok && (targets != '0)) begin
                        issue_d = targets;
                        cnt_d   = tgt_cnt;
                        state_d = StIssue;
                    end else begin
                        issue_d = '0;
                        cnt_d   = 3'd0;
                        state_d = StDone;
                    end
                end
            end
            StIssue: begin
                issue_d = issue_q & ~(snp_hs ? snp_tgt : '0);
                pend_d  = pend_next;
                if (issue_d == '0) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                pend_d = pend_next;
                if (pend_next == '0) begin
                    state_d = StDone;
                end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
                    pend_d  = '0;
                    tmo_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            StDone: begin
                if (done_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            tag_q   <= '0;
            opc_q   <= '0;
            issue_q <= '0;
            pend_q  <= '0;
            cnt_q   <= '0;
            dirty_q <= 1'b0;
            tmo_q   <= 1'b0;
            spur_q  <= 1'b0;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            opc_q   <= opc_d;
            issue_q <= issue_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            dirty_q <= dirty_d;
            tmo_q   <= tmo_d;
            spur_q  <= spur_d;
            tmr_q   <= tmr_d;
        end
    end

endmodule

// File: tb/tb_snoop_dispatcher.sv
// Directed bench for snoop_dispatcher: hand-computed expectations for each step.
module tb_snoop_dispatcher;

    localparam int unsigned WIDTH   = 33;
    localparam int unsigned NUM_RN  = 4;
    localparam int unsigned TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_tag;
    logic [6:0]        req_opcode;
    logic [6:0]        req_nid;
    logic [NUM_RN-1:0] req_sharers;
    logic              snp_valid;
    logic              snp_ready;
    logic [WIDTH-1:0]  snp_tag;
    logic [6:0]        snp_opcode;
    logic [NUM_RN-1:0] snp_tgt;
    logic              rsp_valid;
    logic [NUM_RN-1:0] rsp_src;
    logic              rsp_dirty;
    logic              done_valid;
    logic              done_ready;
    logic [WIDTH-1:0]  done_tag;
    logic [2:0]        done_cnt;
    logic              done_dirty;
    logic              done_tmo;
    logic              err_spur;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    snoop_dispatcher #(
        .WIDTH  (WIDTH),
        .NUM_RN (NUM_RN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tag    (req_tag),
        .req_opcode (req_opcode),
        .req_nid    (req_nid),
        .req_sharers(req_sharers),
        .snp_valid  (snp_valid),
        .snp_ready  (snp_ready),
        .snp_tag    (snp_tag),
        .snp_opcode (snp_opcode),
        .snp_tgt    (snp_tgt),
        .rsp_valid  (rsp_valid),
        .rsp_src    (rsp_src),
        .rsp_dirty  (rsp_dirty),
        .done_valid (done_valid),
        .done_ready (done_ready),
        .done_tag   (done_tag),
        .done_cnt   (done_cnt),
        .done_dirty (done_dirty),
        .done_tmo   (done_tmo),
        .err_spur   (err_spur)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [WIDTH-1:0] tag, input logic [6:0] opc,
                            input logic [6:0] nid, input logic [NUM_RN-1:0] shr);
        req_valid   = 1'b1;
        req_tag     = tag;
        req_opcode  = opc;
        req_nid     = nid;
        req_sharers = shr;
        chk("req_ready_before_req", 64'(req_ready), 64'd1);
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic finish_done();
        done_ready = 1'b1;
        cyc();
        done_ready = 1'b0;
        chk("idle_after_done", 64'(req_ready), 64'd1);
        chk("done_cleared", 64'(done_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_tag = '0; req_opcode = '0; req_nid = '0;
        req_sharers = '0; snp_ready = 1'b0; rsp_valid = 1'b0; rsp_src = '0;
        rsp_dirty = 1'b0; done_ready = 1'b0;
        cyc();
        cyc();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_snp_valid", 64'(snp_valid), 64'd0);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_done_cnt", 64'(done_cnt), 64'd0);
        chk("rst_err_spur", 64'(err_spur), 64'd0);
        chk("rst_snp_tgt", 64'(snp_tgt), 64'd0);
        chk("rst_snp_tag", 64'(snp_tag), 64'd0);
        reset = 1'b0;
        cyc();

        // 1: ReadShared with no sharers completes one cycle after the handshake
        send_req(33'h1_2345_6789, 7'b0000111, 7'b0000001, 4'b0000);
        chk("t1_done_valid", 64'(done_valid), 64'd1);
        chk("t1_snp_valid", 64'(snp_valid), 64'd0);
        chk("t1_cnt", 64'(done_cnt), 64'd0);
        chk("t1_dirty", 64'(done_dirty), 64'd0);
        chk("t1_tmo", 64'(done_tmo), 64'd0);
        chk("t1_tag", 64'(done_tag), 64'h1_2345_6789);
        chk("t1_req_ready", 64'(req_ready), 64'd0);
        finish_done();

        // 2+3: ReadUnique, targets 1001, first snoop stalled 5 cycles
        send_req(33'h0_CAFE_0001, 7'b0000001, 7'b0000010, 4'b1011);
        chk("t2_snp_valid", 64'(snp_valid), 64'd1);
        chk("t2_tgt0", 64'(snp_tgt), 64'b0001);
        chk("t2_opcode", 64'(snp_opcode), 64'b0000111);
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_stall_valid", 64'(snp_valid), 64'd1);
            chk("t3_stall_tgt", 64'(snp_tgt), 64'b0001);
            chk("t3_stall_tag", 64'(snp_tag), 64'h0_CAFE_0001);
        end
        // same-cycle response to the snoop being handshaken is spurious
        snp_ready = 1'b1; rsp_valid = 1'b1; rsp_src = 4'b0001; rsp_dirty = 1'b0;
        cyc();
        rsp_valid = 1'b0;
        chk("t2_spur_same_cycle", 64'(err_spur), 64'd1);
        chk("t2_tgt1", 64'(snp_tgt), 64'b1000);
        chk("t2_valid1", 64'(snp_valid), 64'd1);
        cyc();
        snp_ready = 1'b0;
        chk("t2_spur_cleared", 64'(err_spur), 64'd0);
        chk("t2_wait_no_snp", 64'(snp_valid), 64'd0);
        rsp_valid = 1'b1; rsp_src = 4'b1000; rsp_dirty = 1'b1;
        cyc();
        chk("t2_rsp1_not_done", 64'(done_valid), 64'd0);
        rsp_src = 4'b0001; rsp_dirty = 1'b0;
        cyc();
        rsp_valid = 1'b0;
        chk("t2_done_valid", 64'(done_valid), 64'd1);
        chk("t2_cnt", 64'(done_cnt), 64'd2);
        chk("t2_dirty", 64'(done_dirty), 64'd1);
        chk("t2_tmo", 64'(done_tmo), 64'd0);
        chk("t2_no_spur", 64'(err_spur), 64'd0);
        finish_done();

        // 5: response from an unissued source while 0001 is pending
        send_req(33'h0_0000_0055, 7'b0000111, 7'b0000010, 4'b0001);
        snp_ready = 1'b1;
        cyc();
        snp_ready = 1'b0;
        rsp_valid = 1'b1; rsp_src = 4'b0100; rsp_dirty = 1'b1;
        cyc();
        rsp_valid = 1'b0;
        chk("t5_spur_pulse", 64'(err_spur), 64'd1);
        chk("t5_not_done", 64'(done_valid), 64'd0);
        cyc();
        chk("t5_spur_single", 64'(err_spur), 64'd0);
        chk("t5_still_waiting", 64'(done_valid), 64'd0);
        rsp_valid = 1'b1; rsp_src = 4'b0001; rsp_dirty = 1'b0;
        cyc();
        rsp_valid = 1'b0;
        chk("t5_done_valid", 64'(done_valid), 64'd1);
        chk("t5_cnt", 64'(done_cnt), 64'd1);
        chk("t5_dirty_ignored", 64'(done_dirty), 64'd0);
        finish_done();

        // 4: CleanUnique with no response times out after TIMEOUT WAIT cycles
        send_req(33'h1_0000_0004, 7'b0011011, 7'b0000001, 4'b0100);
        chk("t4_opcode", 64'(snp_opcode), 64'b0001001);
        chk("t4_tgt", 64'(snp_tgt), 64'b0100);
        snp_ready = 1'b1;
        cyc();
        snp_ready = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            cyc();
        end
        chk("t4_not_yet", 64'(done_valid), 64'd0);
        cyc();
        chk("t4_done_valid", 64'(done_valid), 64'd1);
        chk("t4_tmo", 64'(done_tmo), 64'd1);
        chk("t4_cnt", 64'(done_cnt), 64'd1);
        chk("t4_dirty", 64'(done_dirty), 64'd0);
        // pending was cleared by the timeout, so a late response is spurious
        rsp_valid = 1'b1; rsp_src = 4'b0100; rsp_dirty = 1'b1;
        cyc();
        rsp_valid = 1'b0;
        chk("t4_late_spur", 64'(err_spur), 64'd1);
        chk("t4_done_held", 64'(done_valid), 64'd1);
        finish_done();

        // unmapped opcode with sharers goes straight to DONE
        send_req(33'h0_0000_0077, 7'b0010000, 7'b0000001, 4'b1111);
        chk("un_done_valid", 64'(done_valid), 64'd1);
        chk("un_cnt", 64'(done_cnt), 64'd0);
        chk("un_snp_valid", 64'(snp_valid), 64'd0);
        finish_done();

        // 6: reset during WAIT aborts; a late response is only spurious
        send_req(33'h0_0000_0066, 7'b0000001, 7'b0000001, 4'b0010);
        snp_ready = 1'b1;
        cyc();
        snp_ready = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_req_ready", 64'(req_ready), 64'd1);
        chk("t6_snp_valid", 64'(snp_valid), 64'd0);
        chk("t6_done_valid", 64'(done_valid), 64'd0);
        chk("t6_cnt", 64'(done_cnt), 64'd0);
        rsp_valid = 1'b1; rsp_src = 4'b0010; rsp_dirty = 1'b0;
        cyc();
        rsp_valid = 1'b0;
        chk("t6_late_spur", 64'(err_spur), 64'd1);
        chk("t6_no_done", 64'(done_valid), 64'd0);
        cyc();
        chk("t6_spur_end", 64'(err_spur), 64'd0);
        chk("t6_still_idle", 64'(req_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
